afifo_wr_capture: RTL
=====================

// Module: afifo_wr_capture
// PURPOSE
//  Synthesizable, parametrised write-port capture unit for the async FIFO write domain.
//  Samples winc/wfull/wdata every wclk edge and records each write attempt into an internal
//  capture buffer. Each record carries a timestamp and an accepted/rejected flag.
//  Records drain through a valid/ready port to a checker, scoreboard or trace sink.
//  Keeps saturating event counters and an overflow sticky bit for coverage/status.
// PARAMETERS
//  DATA_WIDTH    32  width of wdata and of captured payload
//  CAPT_DEPTH    16  capture buffer entries; power of two, >=2
//  TS_WIDTH      16  free-running timestamp width (wclk cycles)
//  CNT_WIDTH     16  width of each event counter
//  CAPT_REJECTED 0   1: also record write attempts while wfull; 0: accepted writes only
// PORTS
//  wclk          in   1           write-domain clock
//  wrst_n        in   1           asynchronous active-low reset
//  winc          in   1           write request, as seen at the FIFO write port
//  wfull         in   1           FIFO full flag, as seen at the FIFO write port
//  wdata         in   DATA_WIDTH  write data
//  clr           in   1           synchronous clear: flushes buffer, counters and sticky bit
//  cap_valid     out  1           head record available
//  cap_ready     in   1           sink accepts head record
//  cap_data      out  DATA_WIDTH  head record payload
//  cap_ts        out  TS_WIDTH    head record timestamp
//  cap_rejected  out  1           head record was a write attempted while wfull
//  acc_count     out  CNT_WIDTH   accepted writes (winc & !wfull), saturating
//  rej_count     out  CNT_WIDTH   rejected writes (winc & wfull), saturating
//  drop_count    out  CNT_WIDTH   records lost because the buffer was full, saturating
//  overflow      out  1           sticky: at least one record dropped since reset/clr
// BEHAVIOUR
//  Reset (wrst_n=0, asynchronous): buffer empty, cap_valid=0, cap_data/cap_ts/cap_rejected=0,
//   all counters=0, overflow=0, timestamp=0.
//  Timestamp: increments every cycle out of reset and wraps modulo 2^TS_WIDTH.
//   A record holds the timestamp value of the edge at which the event was sampled.
//  Events at a wclk edge:
//   - Accepted (winc=1, wfull=0): acc_count++; push {wdata,ts,0}.
//   - Rejected (winc=1, wfull=1): rej_count++; push {wdata,ts,1} only if CAPT_REJECTED=1.
//   - winc=0: no event.
//  Push/pop rules:
//   - Push is written at edge N; cap_valid rises after edge N (1-cycle latency).
//   - Pop occurs when cap_valid & cap_ready at an edge.
//   - cap_* outputs are stable while cap_valid=1 and cap_ready=0.
//   - Buffer full plus a simultaneous pop: the push succeeds and no drop occurs.
//   - Buffer full and no pop: the record is dropped; drop_count++; overflow<=1.
//   - Empty buffer: cap_valid=0; cap_ready is ignored; cap_* hold their last values.
//  Counters saturate at 2^CNT_WIDTH-1. overflow is cleared only by wrst_n or clr.
//  clr=1 at an edge:
//   - buffer emptied, counters and overflow zeroed.
//   - Any event or pop sampled at the same edge is discarded and not counted.
//   - Timestamp is not affected.
//  Occupancy uses CAPT_DEPTH+1 states (wrap-bit pointers), so full and empty are unambiguous.
//  Reset asserted mid-stream loses all pending records; no partial record is ever presented.
//  Input requirement: winc, wfull and wdata are synchronous to wclk.
// STRUCTURE
//  afifo_pkg carries:
//   - typedef afifo_wr_cap_t {logic [DATA_WIDTH-1:0] data; logic [TS_WIDTH-1:0] ts; logic rejected;}
//     as a parameterised class/struct helper, or fixed at package widths;
//   - localparam helpers for clog2 of CAPT_DEPTH;
//   - the drop/counter saturation function sat_inc().
//  One sub-module, afifo_cap_buf: a single-clock synchronous FIFO with full/empty, push/pop,
//   and registered head output. The top level holds the event decode, timestamp, counters
//   and clr handling.
// TESTING
//  1 Reset: wrst_n low mid-burst -> cap_valid=0, all counts 0, overflow=0 within the same cycle.
//  2 5 writes wdata=1..5, wfull=0, cap_ready=1 -> 5 records data 1..5, consecutive ts,
//    first cap_valid one cycle after first winc, acc_count=5.
//  3 CAPT_REJECTED=1, winc=1 with wfull=1 for 3 cycles -> 3 records with cap_rejected=1,
//    rej_count=3, acc_count unchanged.
//  4 CAPT_DEPTH=16, cap_ready=0, 20 accepted writes -> 16 records held, drop_count=4,
//    overflow=1; drained order is data 1..16.
//  5 Buffer full, winc=1 and cap_ready=1 at the same edge -> no drop; occupancy stays 16.
//  6 clr=1 coincident with winc -> buffer empty, all counters 0, that write is not
//    counted; the timestamp keeps running.

Source files
------------

// File: rtl/afifo_pkg.sv
// Shared types and helpers for the async FIFO write-port capture unit.
package afifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_TS_WIDTH   = 16;
  localparam int unsigned SAT_W          = 64;

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] data;
    logic [DEF_TS_WIDTH-1:0]   ts;
    logic                      rejected;
  } afifo_wr_cap_t;

  function automatic int unsigned ptr_aw(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Counters are widened to SAT_W bits by the caller; w is the real counter width.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v, input int unsigned w);
    logic [SAT_W-1:0] max_v;
    max_v = (w >= SAT_W) ? '1 : ((SAT_W'(1) << w) - SAT_W'(1));
    return (v >= max_v) ? v : v + SAT_W'(1);
  endfunction

endpackage

// File: rtl/afifo_wr_capture_if.sv
// Record drain port of the capture unit: head record plus valid/ready handshake.
interface afifo_wr_capture_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TS_WIDTH   = 16
);
  logic                  cap_valid;
  logic                  cap_ready;
  logic [DATA_WIDTH-1:0] cap_data;
  logic [TS_WIDTH-1:0]   cap_ts;
  logic                  cap_rejected;

  modport master (output cap_valid, cap_data, cap_ts, cap_rejected, input cap_ready);
  modport slave  (input cap_valid, cap_data, cap_ts, cap_rejected, output cap_ready);
endinterface

// File: rtl/afifo_cap_buf.sv
// Single-clock capture FIFO with wrap-bit pointers and a registered head output.
module afifo_cap_buf import afifo_pkg::*; #(
  parameter int unsigned W     = 49,
  parameter int unsigned DEPTH = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic         pop_ready_i,
  input  logic [W-1:0] din_i,
  output logic         valid_o,
  output logic         drop_o,
  output logic [W-1:0] dout_o
);

  localparam int unsigned AW = ptr_aw(DEPTH);

  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] dout_q, dout_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         empty, full, pop, push_ok;

  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop     = !empty && pop_ready_i && !clr_i;
    push_ok = push_i && !clr_i && (!full || pop);
    drop_o  = push_i && !clr_i && full && !pop;
    wr_d    = wr_q + (AW+1)'(push_ok);
    rd_d    = rd_q + (AW+1)'(pop);
    dout_d  = dout_q;
    if (clr_i) begin
      wr_d = '0;
      rd_d = '0;
    end else if (wr_d != rd_d) begin
      // Next head is either the slot written at this very edge or an older stored entry.
      dout_d = (rd_d == wr_q) ? din_i : mem_q[rd_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q   <= '0;
      rd_q   <= '0;
      dout_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      dout_q <= dout_d;
    end
  end

  assign valid_o = !empty;
  assign dout_o  = dout_q;

endmodule

// File: rtl/afifo_wr_capture.sv
// Write-domain capture unit: decodes write attempts, timestamps them, buffers records
// for a valid/ready sink and keeps saturating event counters plus an overflow sticky bit.
module afifo_wr_capture import afifo_pkg::*; #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned CAPT_DEPTH    = 16,
  parameter int unsigned TS_WIDTH      = 16,
  parameter int unsigned CNT_WIDTH     = 16,
  parameter bit          CAPT_REJECTED = 1'b0
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  winc,
  input  logic                  wfull,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  clr,
  afifo_wr_capture_if.master    cap,
  output logic [CNT_WIDTH-1:0]  acc_count,
  output logic [CNT_WIDTH-1:0]  rej_count,
  output logic [CNT_WIDTH-1:0]  drop_count,
  output logic                  overflow
);

  localparam int unsigned REC_W = DATA_WIDTH + TS_WIDTH + 1;

  logic [TS_WIDTH-1:0]  ts_q;
  logic [CNT_WIDTH-1:0] acc_q, acc_d, rej_q, rej_d, drop_q, drop_d;
  logic                 ovf_q, ovf_d;
  logic                 acc_ev, rej_ev, push_ev, drop_ev;
  logic [REC_W-1:0]     rec_in, rec_out;

  assign acc_ev  = winc && !wfull;
  assign rej_ev  = winc && wfull;
  assign push_ev = acc_ev || (rej_ev && CAPT_REJECTED);
  assign rec_in  = {wdata, ts_q, wfull};

  afifo_cap_buf #(
    .W     (REC_W),
    .DEPTH (CAPT_DEPTH)
  ) u_buf (
    .clk_i       (wclk),
    .rst_ni      (wrst_n),
    .clr_i       (clr),
    .push_i      (push_ev),
    .pop_ready_i (cap.cap_ready),
    .din_i       (rec_in),
    .valid_o     (cap.cap_valid),
    .drop_o      (drop_ev),
    .dout_o      (rec_out)
  );

  assign {cap.cap_data, cap.cap_ts, cap.cap_rejected} = rec_out;

  always_comb begin
    acc_d  = acc_q;
    rej_d  = rej_q;
    drop_d = drop_q;
    ovf_d  = ovf_q;
    if (clr) begin
      acc_d  = '0;
      rej_d  = '0;
      drop_d = '0;
      ovf_d  = 1'b0;
    end else begin
      if (acc_ev) acc_d = CNT_WIDTH'(sat_inc(SAT_W'(acc_q), CNT_WIDTH));
      if (rej_ev) rej_d = CNT_WIDTH'(sat_inc(SAT_W'(rej_q), CNT_WIDTH));
      if (drop_ev) begin
        drop_d = CNT_WIDTH'(sat_inc(SAT_W'(drop_q), CNT_WIDTH));
        ovf_d  = 1'b1;
      end
    end
  end

  // Timestamp free-runs; clr deliberately leaves it alone.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      ts_q   <= '0;
      acc_q  <= '0;
      rej_q  <= '0;
      drop_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      ts_q   <= ts_q + TS_WIDTH'(1);
      acc_q  <= acc_d;
      rej_q  <= rej_d;
      drop_q <= drop_d;
      ovf_q  <= ovf_d;
    end
  end

  assign acc_count  = acc_q;
  assign rej_count  = rej_q;
  assign drop_count = drop_q;
  assign overflow   = ovf_q;

endmodule
